// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants, FSM state encoding and baud helper for the
//            FIFO-to-UART sender and its byte serialiser.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Start bit + 8 data bits + stop bit
  localparam int FRAME_BITS = 10;

  // One-hot state encodings of the sender FSM
  localparam logic [5:0] S_IDLE    = 6'b000001;
  localparam logic [5:0] S_RD_REQ  = 6'b000010;
  localparam logic [5:0] S_RD_WAIT = 6'b000100;
  localparam logic [5:0] S_LOAD    = 6'b001000;
  localparam logic [5:0] S_SEND    = 6'b010000;
  localparam logic [5:0] S_NEXT    = 6'b100000;

  typedef enum logic [5:0] {
    ST_IDLE    = S_IDLE,
    ST_RD_REQ  = S_RD_REQ,
    ST_RD_WAIT = S_RD_WAIT,
    ST_LOAD    = S_LOAD,
    ST_SEND    = S_SEND,
    ST_NEXT    = S_NEXT
  } state_t;

  // Clocks per UART bit (integer division, truncating)
  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_byte_serializer
// Purpose  : Shifts one byte out as an 8N1 frame (start 0, LSB first, stop 1).
//            A load pulse starts the frame; txd falls on the following cycle.
//            frame_end flags the last cycle of the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_serializer
  import uart_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       txd,
  output logic       frame_end
);

  // A baud divide of 1 still needs a one-bit counter that is permanently 0
  localparam int               CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       shift_reg;
  logic             active;
  logic             bit_end;

  assign bit_end   = active && (baud_cnt == CNT_LAST);
  assign frame_end = bit_end && (bit_idx == IDX_LAST);

  // Baud counter, bit index and shift register; txd is registered so it
  // changes only on bit boundaries
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      txd       <= 1'b1;
      active    <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= din;
      txd       <= 1'b0;
      active    <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == IDX_LAST) begin
          active  <= 1'b0;
          bit_idx <= '0;
          txd     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx < 4'd8) begin
            txd       <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            txd <= 1'b1;
          end
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_uart_sender
// Purpose  : On start, pops BURST_LEN bytes from a 1-cycle-latency FIFO and
//            sends each as an 8N1 UART frame. Reports busy, a done pulse and
//            the number of bytes fully sent.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_sender
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int BURST_LEN = 256
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_dout,
  output logic       uart_txd,
  output logic       busy,
  output logic       done,
  output logic [8:0] byte_cnt
);

  localparam int         BPS_CNT    = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [8:0] BURST_LAST = 9'(BURST_LEN);

  state_t     state;
  logic       load;
  logic       frame_end;
  logic [8:0] cnt_next;

  assign cnt_next = byte_cnt + 9'd1;

  // The read strobe qualifies RD_REQ with the live empty flag so an empty
  // FIFO is never popped; it lasts exactly the one RD_REQ cycle that leaves.
  assign fifo_rd_en = (state == ST_RD_REQ) && !fifo_empty;

  // fifo_dout is valid from RD_WAIT onward and held, so LOAD captures it
  assign load = (state == ST_LOAD);

  uart_byte_serializer #(
    .BPS_CNT (BPS_CNT)
  ) u_serializer (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .load      (load),
    .din       (fifo_dout),
    .txd       (uart_txd),
    .frame_end (frame_end)
  );

  // Burst sequencing FSM with registered busy/done/byte_cnt; a start that
  // coincides with the done pulse is treated as arriving while still busy
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            state    <= ST_RD_REQ;
            busy     <= 1'b1;
            byte_cnt <= '0;
          end
        end
        ST_RD_REQ: begin
          if (!fifo_empty) state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: state <= ST_LOAD;
        ST_LOAD:    state <= ST_SEND;
        ST_SEND: begin
          if (frame_end) state <= ST_NEXT;
        end
        ST_NEXT: begin
          byte_cnt <= cnt_next;
          if (cnt_next == BURST_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_RD_REQ;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_sender
// Purpose  : Self-checking bench for fifo_uart_sender. Three instances
//            (BURST_LEN 1, 4, 256) share one FIFO model and a UART decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_sender;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] start_v;
  logic       fifo_empty;
  logic [7:0] fifo_dout = '0;
  logic [2:0] rd_v, txd_v, busy_v, done_v;
  logic [8:0] cnt0, cnt1, cnt2;

  always #5 sys_clk = ~sys_clk;

  fifo_uart_sender #(.CLK_FREQ(1000000), .UART_BPS(100000), .BURST_LEN(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_v[0]), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_v[0]), .fifo_dout(fifo_dout), .uart_txd(txd_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .byte_cnt(cnt0));

  fifo_uart_sender #(.CLK_FREQ(1000000), .UART_BPS(100000), .BURST_LEN(4)) u_dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_v[1]), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_v[1]), .fifo_dout(fifo_dout), .uart_txd(txd_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .byte_cnt(cnt1));

  fifo_uart_sender #(.CLK_FREQ(1000000), .UART_BPS(100000), .BURST_LEN(256)) u_dut256 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_v[2]), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_v[2]), .fifo_dout(fifo_dout), .uart_txd(txd_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .byte_cnt(cnt2));

  // FIFO model: 1-cycle read latency, data held until the next pop
  logic [7:0] mem [512];
  logic [8:0] wr_ptr = '0;
  logic [8:0] rd_ptr = '0;
  logic       rd_any;
  assign rd_any     = |rd_v;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge sys_clk) begin
    if (rd_any && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 9'd1;
    end
  end

  // Event counters
  int cyc = 0, rd_cnt = 0, viol_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (rd_any) rd_cnt <= rd_cnt + 1;
    if (rd_any && fifo_empty) viol_cnt <= viol_cnt + 1;
    if (|done_v) done_cnt <= done_cnt + 1;
    if (|(done_v & busy_v)) overlap_cnt <= overlap_cnt + 1;
  end

  // Selected instance outputs
  int         sel = 1;
  logic       txd_s, busy_s, done_s;
  logic [8:0] cnt_s;
  always_comb begin
    txd_s  = txd_v[sel];
    busy_s = busy_v[sel];
    done_s = done_v[sel];
    case (sel)
      0:       cnt_s = cnt0;
      1:       cnt_s = cnt1;
      default: cnt_s = cnt2;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // UART decoder: samples mid-bit, records {stop, data} and the start cycle
  logic [8:0] rx_mem [1024];
  int         rx_cyc [1024];
  int         rx_wr = 0;
  int         rx_rd = 0;

  initial begin : rx_mon
    logic [8:0] v;
    int         c0;
    forever begin
      tick();
      if (txd_s === 1'b0) begin
        c0 = cyc;
        repeat (5) tick();
        for (int i = 0; i < 9; i++) begin
          repeat (10) tick();
          v[i] = txd_s;
        end
        rx_mem[rx_wr] = v;
        rx_cyc[rx_wr] = c0;
        rx_wr++;
      end
    end
  end

  // Scoreboard of bytes expected on the line
  logic [7:0] exp_q [$];

  task automatic push(input logic [7:0] b, input bit track);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 9'd1;
    if (track) exp_q.push_back(b);
  endtask

  logic line_log [32768];

  // Pulse start, optionally re-pulse mid-burst / on done, optionally push the
  // remaining bytes later; returns start-to-done latency in cycles (-1 = timeout)
  task automatic run_burst(input int s, input int extra_at, input bit on_done,
                           input int push_at, input logic [3:0][7:0] d,
                           input int pre, input int n, input int limit, output int lat);
    sel = s;
    lat = -1;
    start_v[s] = 1'b1;
    tick();
    start_v = '0;
    for (int k = 1; k <= limit; k++) begin
      line_log[k] = txd_s;
      if (k == 1) chk("busy_after_start", {31'd0, busy_s}, 32'd1);
      if (done_s) begin
        lat = k;
        if (on_done) begin
          start_v[s] = 1'b1;
          tick();
          start_v = '0;
        end
        break;
      end
      if (push_at != 0 && k == push_at)
        for (int j = pre; j < n; j++) push(d[j], 1'b1);
      start_v[s] = (k == extra_at);
      tick();
    end
    start_v = '0;
    if (lat < 0) $display("FAIL done_timeout: no done within %0d cycles", limit);
  endtask

  task automatic check_burst(input string tag, input int n, input int exp_lat, input int lat,
                             input int rd0, input int dn0, input bit gaps);
    logic [7:0] eb;
    int         bad_gaps;
    repeat (20) tick();
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_byte_cnt"}, {23'd0, cnt_s}, n);
    chk({tag, "_busy_end"}, {31'd0, busy_s}, 32'd0);
    chk({tag, "_rd_pulses"}, rd_cnt - rd0, n);
    chk({tag, "_done_pulses"}, done_cnt - dn0, 32'd1);
    chk({tag, "_rd_while_empty"}, viol_cnt, 32'd0);
    chk({tag, "_done_busy_overlap"}, overlap_cnt, 32'd0);
    chk({tag, "_frames"}, rx_wr - rx_rd, n);
    bad_gaps = 0;
    for (int j = 0; j < n; j++) begin
      eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, j), {23'd0, rx_mem[rx_rd]}, {23'd0, 1'b1, eb});
      if (j > 0 && (rx_cyc[rx_rd] - rx_cyc[rx_rd-1] != 104)) bad_gaps++;
      rx_rd++;
    end
    if (gaps) chk({tag, "_bad_gaps"}, bad_gaps, 32'd0);
    exp_q.delete();
    rx_rd = rx_wr;
  endtask

  typedef struct {
    int              s;
    int              n;
    int              pre;
    logic [3:0][7:0] d;
    int              extra_at;
    bit              on_done;
    int              push_at;
    int              exp_lat;
    bit              gaps;
  } vec_t;

  vec_t vt [4];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         lat, rd0, dn0, k;
    logic [0:9] pat;
    int         bad;
    string      tag;

    // s, n, pre, bytes{d3,d2,d1,d0}, extra_at, on_done, push_at, latency, gaps
    vt[0] = '{0, 1, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, 0,   1'b0, 0,   105, 1'b1};
    vt[1] = '{1, 4, 4, {8'h81, 8'h55, 8'hFF, 8'h00}, 0,   1'b0, 0,   417, 1'b1};
    vt[2] = '{1, 4, 2, {8'hF0, 8'h0F, 8'hC3, 8'h3C}, 0,   1'b0, 300, 508, 1'b0};
    vt[3] = '{1, 4, 4, {8'hEF, 8'hBE, 8'hAD, 8'hDE}, 150, 1'b1, 0,   417, 1'b1};

    // Reset state
    sys_rst = 1'b1;
    start_v = '0;
    repeat (3) tick();
    chk("rst_txd", {29'd0, txd_v}, 32'd7);
    chk("rst_busy", {29'd0, busy_v}, 32'd0);
    chk("rst_done", {29'd0, done_v}, 32'd0);
    chk("rst_rd_en", {29'd0, rd_v}, 32'd0);
    chk("rst_byte_cnt", {23'd0, cnt0 | cnt1 | cnt2}, 32'd0);
    sys_rst = 1'b0;
    tick();

    // Reset 35 cycles into a frame of 0x00 (line low there)
    push(8'h00, 1'b0);
    sel = 1;
    start_v[1] = 1'b1;
    tick();
    start_v = '0;
    k = 0;
    while (txd_s !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    chk("midrst_frame_started", {31'd0, txd_s}, 32'd0);
    repeat (35) tick();
    chk("midrst_line_low_before", {31'd0, txd_s}, 32'd0);
    sys_rst = 1'b1;
    tick();
    chk("midrst_txd", {31'd0, txd_s}, 32'd1);
    chk("midrst_busy", {31'd0, busy_s}, 32'd0);
    sys_rst = 1'b0;
    repeat (3) tick();
    chk("midrst_idle_busy", {31'd0, busy_s}, 32'd0);
    chk("midrst_idle_txd", {31'd0, txd_s}, 32'd1);
    repeat (120) tick();
    rx_rd = rx_wr;

    // Table-driven bursts
    for (int r = 0; r < 4; r++) begin
      tag = $sformatf("vec%0d", r);
      for (int j = 0; j < vt[r].pre; j++) push(vt[r].d[j], 1'b1);
      rd0 = rd_cnt;
      dn0 = done_cnt;
      run_burst(vt[r].s, vt[r].extra_at, vt[r].on_done, vt[r].push_at,
                vt[r].d, vt[r].pre, vt[r].n, 2000, lat);
      if (r == 0) begin
        // Exact line pattern of 0xA5, 10 cycles per bit, frame in cycles 4..103
        pat = 10'b0101001011;
        bad = 0;
        for (int i = 0; i < 100; i++)
          if (line_log[4 + i] !== pat[i / 10]) bad++;
        if (line_log[3] !== 1'b1 || line_log[104] !== 1'b1) bad++;
        chk("vec0_line_pattern_errs", bad, 32'd0);
      end
      if (vt[r].push_at != 0) begin
        bad = 0;
        for (int i = 209; i < vt[r].push_at; i++)
          if (line_log[i] !== 1'b1) bad++;
        chk("underflow_line_low_cycles", bad, 32'd0);
      end
      check_burst(tag, vt[r].n, vt[r].exp_lat, lat, rd0, dn0, vt[r].gaps);
    end

    // Full-length burst of 256 bytes 0..255
    for (int j = 0; j < 256; j++) push(8'(j), 1'b1);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    run_burst(2, 0, 1'b0, 0, '0, 256, 256, 30000, lat);
    check_burst("full", 256, 26625, lat, rd0, dn0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
